// File: rtl/speed_step_divider.sv
// rtl/speed_step_divider.sv - speed up/down/reset events to saturated terminal count, plus tick divider
module speed_step_divider #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned DEFAULT_COUNT = 3472,
    parameter int unsigned STEP          = 10,
    parameter int unsigned MIN_COUNT     = 100,
    parameter int unsigned MAX_COUNT     = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             speed_up_event,
    input  logic             speed_down_event,
    input  logic             speed_reset_event,
    output logic [WIDTH-1:0] clk_count_to,
    output logic             tick,
    output logic             at_min,
    output logic             at_max,
    output logic             rate_changed
);

    localparam logic [WIDTH-1:0] DEF_C  = WIDTH'(DEFAULT_COUNT);
    localparam logic [WIDTH-1:0] STEP_C = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] MIN_C  = WIDTH'(MIN_COUNT);
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_COUNT);
    // Thresholds precomputed so the per-cycle compares never wrap.
    localparam logic [WIDTH-1:0] UP_FLOOR = WIDTH'(MIN_COUNT + STEP);
    localparam logic [WIDTH-1:0] DN_CEIL  = WIDTH'(MAX_COUNT - STEP);

    logic             up_hist_q, dn_hist_q, rst_hist_q;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             changed_q, changed_d;
    logic             up_rise, dn_rise, rst_rise;

    always_comb begin
        up_rise  = speed_up_event & ~up_hist_q;
        dn_rise  = speed_down_event & ~dn_hist_q;
        rst_rise = speed_reset_event & ~rst_hist_q;

        count_d = count_q;
        if (rst_rise) begin
            count_d = DEF_C;
        end else if (up_rise && !dn_rise) begin
            count_d = (count_q >= UP_FLOOR) ? count_q - STEP_C : MIN_C;
        end else if (dn_rise && !up_rise) begin
            count_d = (count_q <= DN_CEIL) ? count_q + STEP_C : MAX_C;
        end
        changed_d = (count_d != count_q);

        // Compare against the current count; a shrinking count catches up on the next edge.
        if (div_q >= count_q) begin
            div_d  = '0;
            tick_d = 1'b1;
        end else begin
            div_d  = div_q + 1'b1;
            tick_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            up_hist_q  <= 1'b1;
            dn_hist_q  <= 1'b1;
            rst_hist_q <= 1'b1;
            count_q    <= DEF_C;
            div_q      <= '0;
            tick_q     <= 1'b0;
            changed_q  <= 1'b0;
        end else begin
            up_hist_q  <= speed_up_event;
            dn_hist_q  <= speed_down_event;
            rst_hist_q <= speed_reset_event;
            count_q    <= count_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            changed_q  <= changed_d;
        end
    end

    assign clk_count_to = count_q;
    assign tick         = tick_q;
    assign rate_changed = changed_q;
    assign at_min       = (count_q == MIN_C);
    assign at_max       = (count_q == MAX_C);

endmodule

// File: doc/speed_step_divider.md
# speed_step_divider

Parametrised playback-rate controller with built-in sample-strobe divider. Converts speed up/down/reset button events into a saturated divider terminal count, then divides `clk` by that count to produce a one-cycle sample `tick` for the audio path. Sits between the keyboard/button event decoder and the audio sample fetch logic, and replaces the free-running adjust-by-10 count register.

## Interface
- `WIDTH`, 32: width of the count and divider registers.
- `DEFAULT_COUNT`, 3472: terminal count loaded on reset and on a speed-reset event (nominal rate).
- `STEP`, 10: amount added or subtracted per accepted event.
- `MIN_COUNT`, 100: lower saturation limit (fastest rate).
- `MAX_COUNT`, 100000: upper saturation limit (slowest rate).
- Legal parameters: 1 ≤ MIN_COUNT ≤ DEFAULT_COUNT ≤ MAX_COUNT < 2^WIDTH; STEP ≥ 1; MAX_COUNT − STEP ≥ MIN_COUNT.

Ports:
- `clk` input 1: system clock; all state is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `speed_up_event` input 1: level or pulse; rising edge requests faster rate (count − STEP).
- `speed_down_event` input 1: rising edge requests slower rate (count + STEP).
- `speed_reset_event` input 1: rising edge restores DEFAULT_COUNT.
- `clk_count_to` output WIDTH: current divider terminal count.
- `tick` output 1: registered one-cycle strobe, period clk_count_to+1 cycles.
- `at_min` output 1: high while clk_count_to == MIN_COUNT (combinational from register).
- `at_max` output 1: high while clk_count_to == MAX_COUNT (combinational from register).
- `rate_changed` output 1: registered one-cycle pulse whenever clk_count_to takes a new value.

## Operation
- Edge detection: one history flop per event input; rise = input & ~history. Holding an input high produces exactly one step. On `reset`, all history flops are set to 1, so an input held high through reset does not trigger.
- Count update priority, evaluated per cycle on the detected rises:
  - `speed_reset_event` rise: load DEFAULT_COUNT and ignore the others.
  - Up and down rises in the same cycle: no change.
  - Up rise: count ≥ MIN_COUNT+STEP ? count−STEP : MIN_COUNT.
  - Down rise: count ≤ MAX_COUNT−STEP ? count+STEP : MAX_COUNT.
  - Otherwise hold.
- Comparisons must be formed so no WIDTH-bit wrap occurs. Never compute count−STEP below zero or count+STEP above 2^WIDTH−1 unguarded.
- `rate_changed` pulses only when the new value differs from the old. A saturated step, or a reset-event at DEFAULT_COUNT, does not pulse.
- Divider: `div_cnt` (WIDTH bits).
  - If div_cnt ≥ clk_count_to: div_cnt←0, tick←1.
  - Else: div_cnt←div_cnt+1, tick←0.
  - The ≥ compare guarantees a tick within one cycle when the count shrinks below div_cnt. There is no long wrap.
  - A count change does not reset div_cnt. The new period takes effect from the current position.

## Timing
- Reset values: clk_count_to=DEFAULT_COUNT, div_cnt=0, tick=0, rate_changed=0, history=1. at_min and at_max follow the count (both 0 for defaults).
- Event latency: an input rising before edge N is sampled at edge N. clk_count_to holds its new value after edge N. rate_changed is high for the cycle after edge N.
- Minimum event spacing: an input must be low for at least one sampled cycle before it can produce another rise.
- After reset deasserts, the first tick occurs at the edge where div_cnt==clk_count_to, i.e. clk_count_to+1 edges after reset release. Subsequent ticks follow every clk_count_to+1 cycles.
- `reset` overrides everything in the same cycle, including events sampled on that edge.

## Test plan
- Reset, then run 7000 cycles: clk_count_to=3472, at_min=at_max=0. Ticks are exactly 3473 cycles apart, and the first tick arrives 3473 edges after reset release.
- Hold speed_up_event high for 5 cycles, then release: clk_count_to=3462 (single step), one rate_changed pulse. Next tick spacing is 3463.
- With MIN_COUNT=3452, apply three separate up pulses: counts go 3462, 3452, 3452. at_min=1 after the second pulse. rate_changed fires twice, not three times.
- With MAX_COUNT=3480, apply two down pulses: counts go 3480, 3480, at_max=1. With WIDTH=12 and MAX_COUNT=4095, STEP=10, a down pulse at 4090 yields 4095 (no wrap).
- Up and down rising on the same edge: no change, no rate_changed. Reset-event and up rising together: clk_count_to=3472.
- Set count to 3372, assert `reset` mid-divide with speed_up_event held high through release: count=3472, div_cnt=0, no step after release until the input goes low and high again.
